// File: rtl/led_scan_rx.sv
// Receive-side monitor for the multiplexed 6-digit 7-segment bus: waits for a
// stable digit enable, decodes each digit and rebuilds MM:SS plus the DP bits per frame.
module led_scan_rx #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic [5:0]  o_dp,
    output logic        o_frame_vld,
    output logic        o_frame_err,
    output logic        o_lost
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t        state;
    logic [5:0]    enb_q;
    logic [5:0]    mask;
    logic [5:0]    dp_r;
    logic [23:0]   dig_r;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] idle_cnt;
    logic          sticky;
    logic          close_pend;

    logic          changed, legal, legal_chg, capture;
    logic          lost_nxt, lost_rise, frame_err, sticky_base;
    logic [2:0]    idx, n_low;
    logic [5:0]    cap_bit, mask_base;
    logic [3:0]    cap_dig;
    logic [3:0]    d0, d1, d2, d3, d4, d5;
    logic [5:0]    sec_val, min_val;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h7E:   return 4'd0;
            7'h30:   return 4'd1;
            7'h6D:   return 4'd2;
            7'h79:   return 4'd3;
            7'h33:   return 4'd4;
            7'h5B:   return 4'd5;
            7'h5F:   return 4'd6;
            7'h70:   return 4'd7;
            7'h7F:   return 4'd8;
            7'h73:   return 4'd9;
            7'h00:   return 4'hF;
            default: return 4'hE;
        endcase
    endfunction

    always_comb begin
        n_low = '0;
        idx   = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (!i_seg_enb[i]) begin
                n_low = n_low + 3'd1;
                idx   = 3'(i);
            end
        end
        legal     = (n_low == 3'd1);
        changed   = (i_seg_enb != enb_q);
        legal_chg = changed && legal;
        capture   = (state == SETTLE) && !changed && (stab_cnt == SW'(SETTLE_CYC - 1));
        cap_bit   = 6'b000001 << idx;
        cap_dig   = seg_decode(i_seg);
        // a legal enable change on the timeout cycle keeps o_lost low
        lost_nxt  = !legal_chg && (idle_cnt >= TW'(TIMEOUT_CYC - 1));
        lost_rise = lost_nxt && !o_lost;
        // frame close and timeout both start a fresh mask; a same-edge capture lands in it
        mask_base   = (close_pend || lost_rise) ? '0 : mask;
        sticky_base = (close_pend || lost_rise) ? 1'b0 : sticky;
        {d5, d4, d3, d2, d1, d0} = dig_r;
        frame_err = sticky || (d0 > 4'd9) || (d1 > 4'd5) || (d2 > 4'd9) || (d3 > 4'd5)
                    || (d4 != 4'hF) || (d5 != 4'hF);
        sec_val   = {2'b00, d1} * 6'd10 + {2'b00, d0};
        min_val   = {2'b00, d3} * 6'd10 + {2'b00, d2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            enb_q       <= '1;
            mask        <= '0;
            dp_r        <= '0;
            dig_r       <= '0;
            stab_cnt    <= '0;
            idle_cnt    <= '0;
            sticky      <= 1'b0;
            close_pend  <= 1'b0;
            o_digits    <= '0;
            o_sec       <= '0;
            o_min       <= '0;
            o_dp        <= '0;
            o_frame_vld <= 1'b0;
            o_frame_err <= 1'b0;
            o_lost      <= 1'b0;
        end else begin
            enb_q <= i_seg_enb;

            if (changed)
                stab_cnt <= '0;
            else if (stab_cnt != '1)
                stab_cnt <= stab_cnt + 1'b1;

            if (legal_chg)
                idle_cnt <= '0;
            else if (idle_cnt != '1)
                idle_cnt <= idle_cnt + 1'b1;

            o_lost      <= lost_nxt;
            o_frame_vld <= 1'b0;
            close_pend  <= 1'b0;
            mask        <= mask_base;
            sticky      <= sticky_base;

            if (close_pend) begin
                o_digits    <= dig_r;
                o_dp        <= dp_r;
                o_frame_err <= frame_err;
                o_frame_vld <= 1'b1;
                if (!frame_err) begin
                    o_sec <= sec_val;
                    o_min <= min_val;
                end
            end

            case (state)
                IDLE: begin
                    if (legal) begin
                        state    <= SETTLE;
                        stab_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        state <= legal ? SETTLE : IDLE;
                    end else if (capture) begin
                        state                    <= HOLD;
                        dig_r[{idx, 2'b00} +: 4] <= cap_dig;
                        dp_r[idx]                <= i_seg_dp;
                        mask                     <= mask_base | cap_bit;
                        sticky                   <= sticky_base | mask_base[idx];
                        close_pend               <= ((mask_base | cap_bit) == 6'h3F);
                    end
                end
                HOLD: begin
                    if (changed)
                        state <= legal ? SETTLE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_rx.sv
// Scoreboard bench for led_scan_rx: scans digit patterns onto the bus, queues the
// expected frame at the final digit and compares when o_frame_vld pulses.
module tb_led_scan_rx;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned DWELL   = 12;
    localparam int unsigned GAP     = 2;

    localparam logic [6:0] SEG_TBL [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

    typedef struct {
        logic [23:0] digits;
        logic [5:0]  dp;
        logic        err;
        logic [5:0]  sec;
        logic [5:0]  min;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic [23:0] o_digits;
    logic [5:0]  o_sec, o_min, o_dp;
    logic        o_frame_vld, o_frame_err, o_lost;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          model_sec = 0;
    int          model_min = 0;

    led_scan_rx #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
        .o_digits(o_digits), .o_sec(o_sec), .o_min(o_min), .o_dp(o_dp),
        .o_frame_vld(o_frame_vld), .o_frame_err(o_frame_err), .o_lost(o_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_dec(input logic [6:0] s);
        if (s == 7'h00) return 4'hF;
        for (int i = 0; i < 10; i++)
            if (SEG_TBL[i] == s) return 4'(i);
        return 4'hE;
    endfunction

    task automatic check_cleared(input string pfx);
        check({pfx, "_digits"}, 32'(o_digits), 0);
        check({pfx, "_sec"}, 32'(o_sec), 0);
        check({pfx, "_min"}, 32'(o_min), 0);
        check({pfx, "_dp"}, 32'(o_dp), 0);
        check({pfx, "_vld"}, 32'(o_frame_vld), 0);
        check({pfx, "_err"}, 32'(o_frame_err), 0);
        check({pfx, "_lost"}, 32'(o_lost), 0);
    endtask

    // entered and left on a negedge; ends with a short all-high blanking gap
    task automatic show_digit(input int unsigned idx, input logic [6:0] seg, input logic dp);
        i_seg_enb = ~(6'b000001 << idx);
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (DWELL) @(negedge clk);
        i_seg_enb = '1;
        i_seg     = '0;
        i_seg_dp  = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [5:0][6:0] segs, input logic [5:0] dps, input logic recap);
        exp_t        e;
        logic [3:0]  d [6];
        logic        err;
        for (int i = 0; i < 6; i++) begin
            d[i] = model_dec(segs[i]);
            e.digits[i*4 +: 4] = d[i];
        end
        err = recap || (d[0] > 9) || (d[1] > 5) || (d[2] > 9) || (d[3] > 5)
              || (d[4] != 4'hF) || (d[5] != 4'hF);
        if (!err) begin
            model_sec = int'(d[1]) * 10 + int'(d[0]);
            model_min = int'(d[3]) * 10 + int'(d[2]);
        end
        e.dp  = dps;
        e.err = err;
        e.sec = 6'(model_sec);
        e.min = 6'(model_min);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                e.cyc = cyc + SETTLE + 2;
                sb.push_back(e);
            end
            show_digit(i, segs[i], dps[i]);
            if (recap && i == 1) show_digit(1, segs[1], dps[1]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_frame_vld) begin
            if (sb.size() == 0) begin
                check("vld_unexpected", 32'(o_frame_vld), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_cycle", cyc, e.cyc);
                check("frame_digits", 32'(o_digits), 32'(e.digits));
                check("frame_dp", 32'(o_dp), 32'(e.dp));
                check("frame_err", 32'(o_frame_err), 32'(e.err));
                check("frame_sec", 32'(o_sec), 32'(e.sec));
                check("frame_min", 32'(o_min), 32'(e.min));
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish before cycle limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_seg = '0; i_seg_dp = 1'b0; i_seg_enb = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");

        // short glitch on digit 3 and a two-low enable: neither may capture
        i_seg = 7'h30; i_seg_enb = 6'h37;
        repeat (2) @(negedge clk);
        i_seg_enb = '1;
        repeat (3) @(negedge clk);
        i_seg_enb = 6'h3C;
        repeat (DWELL) @(negedge clk);
        i_seg_enb = '1; i_seg = '0;
        repeat (GAP) @(negedge clk);

        scan_frame({7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h33}, 6'b000100, 1'b0);   // 12:34
        scan_frame({7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h01}, 6'b101001, 1'b0);   // d0 illegal
        scan_frame({7'h00, 7'h30, 7'h30, 7'h6D, 7'h79, 7'h33}, 6'b000000, 1'b0);   // d4 not blank
        scan_frame({7'h00, 7'h00, 7'h7E, 7'h7E, 7'h5F, 7'h7E}, 6'b010000, 1'b0);   // d1 = 6

        // partial frame then timeout; the partial mask must be discarded
        show_digit(0, 7'h7E, 1'b0);
        show_digit(1, 7'h5B, 1'b0);
        repeat (20) @(negedge clk);
        check("lost_early", 32'(o_lost), 0);
        repeat (TIMEOUT) @(negedge clk);
        check("lost_set", 32'(o_lost), 1);
        i_seg_enb = 6'h3E; i_seg = 7'h7E;
        @(negedge clk);
        check("lost_clear", 32'(o_lost), 0);
        scan_frame({7'h00, 7'h00, 7'h33, 7'h5B, 7'h5B, 7'h7E}, 6'b000110, 1'b0);   // 45:50

        scan_frame({7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h33}, 6'b000000, 1'b1);   // recapture

        show_digit(0, 7'h73, 1'b1);
        show_digit(1, 7'h5B, 1'b0);
        show_digit(2, 7'h73, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_cleared("midrst");
        model_sec = 0;
        model_min = 0;
        scan_frame({7'h00, 7'h00, 7'h5B, 7'h73, 7'h5B, 7'h73}, 6'b001000, 1'b0);   // 59:59

        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
